// File: rtl/adc_frame_align_if.sv
// -----------------------------------------------------------------------------
// adc_frame_align_if
// Groups the control and status signals of the ADC frame aligner.
//   adc_en      level enable from the GPIO (0 forces the aligner idle)
//   restart     one-cycle pulse that starts a fresh alignment attempt
//   frm_data    deserialized frame-clock word, one new word per adc_clk
//   bitslip     one-cycle pulse to every ISERDES BITSLIP input
//   aligned     high while the frame word is locked
//   align_err   high after every bitslip position has been tried
//   slip_count  bitslips issued in the current attempt
//   relock_cnt  lock losses since reset, saturating
// Modports: master drives the controls and reads the status (GPIO/bench side);
// slave is the aligner itself.
// -----------------------------------------------------------------------------
interface adc_frame_align_if;
  logic       adc_en;
  logic       restart;
  logic [7:0] frm_data;
  logic       bitslip;
  logic       aligned;
  logic       align_err;
  logic [3:0] slip_count;
  logic [7:0] relock_cnt;

  modport master (
    output adc_en, restart, frm_data,
    input  bitslip, aligned, align_err, slip_count, relock_cnt
  );

  modport slave (
    input  adc_en, restart, frm_data,
    output bitslip, aligned, align_err, slip_count, relock_cnt
  );
endinterface

// File: rtl/adc_frame_align.sv
// -----------------------------------------------------------------------------
// adc_frame_align
// Word-alignment sequencer for the 8-lane ADC deserializers, clocked by the
// divided DCLK. It compares the deserialized frame-clock word against
// FRAME_PATTERN and pulses bitslip until the word lines up, then watches the
// lock and re-aligns on its own when the word drifts away.
// Ports:
//   adc_clk  deserializer divided clock, all logic on the rising edge
//   adc_rst  asynchronous active-high reset
//   bus      adc_frame_align_if.slave (controls in, status out)
// All status outputs are registered.
// -----------------------------------------------------------------------------
module adc_frame_align #(
  parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
  parameter int unsigned SETTLE_CYCLES = 16,  // 1..255
  parameter int unsigned MATCH_COUNT   = 64,  // 1..255
  parameter int unsigned MAX_SLIPS     = 8,   // 1..15
  parameter int unsigned LOSS_THRESH   = 4    // 1..255
) (
  input  logic             adc_clk,
  input  logic             adc_rst,
  adc_frame_align_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } state_t;

  // Counters compare against "last value" so they never need a wider width
  // than their parameter maximum.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
  localparam logic [7:0] LOSS_LAST   = 8'(LOSS_THRESH - 1);
  localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);

  state_t     state;
  logic [7:0] settle_cnt;
  logic [7:0] match_cnt;
  logic [7:0] miss_cnt;
  logic       frm_match;

  assign frm_match = (bus.frm_data == FRAME_PATTERN);

  // NOTE: every register in this block uses non-blocking assignment so all
  // state and outputs update together from the same pre-edge values.
  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      state          <= S_IDLE;
      settle_cnt     <= '0;
      match_cnt      <= '0;
      miss_cnt       <= '0;
      bus.bitslip    <= 1'b0;
      bus.aligned    <= 1'b0;
      bus.align_err  <= 1'b0;
      bus.slip_count <= '0;
      bus.relock_cnt <= '0;
    end else begin
      // NOTE: the status outputs default low every cycle; the branch that
      // enters or stays in LOCKED/FAIL/SLIP re-asserts its own flag, so the
      // flags always reflect the state being registered this edge.
      bus.bitslip   <= 1'b0;
      bus.aligned   <= 1'b0;
      bus.align_err <= 1'b0;

      if (!bus.adc_en) begin
        state          <= S_IDLE;
        settle_cnt     <= '0;
        match_cnt      <= '0;
        miss_cnt       <= '0;
        bus.slip_count <= '0;
      end else if (bus.restart) begin
        // A restart in SLIP lets that cycle's bitslip pulse stand; it was
        // registered on the way in.
        state          <= S_SETTLE;
        settle_cnt     <= '0;
        match_cnt      <= '0;
        miss_cnt       <= '0;
        bus.slip_count <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            // adc_en is known high here.
            state          <= S_SETTLE;
            settle_cnt     <= '0;
            match_cnt      <= '0;
            miss_cnt       <= '0;
            bus.slip_count <= '0;
          end

          S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state      <= S_CHECK;
              settle_cnt <= '0;
              match_cnt  <= '0;
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end

          S_CHECK: begin
            if (frm_match) begin
              if (match_cnt == MATCH_LAST) begin
                state       <= S_LOCKED;
                miss_cnt    <= '0;
                bus.aligned <= 1'b1;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else if (bus.slip_count == SLIP_MAX) begin
              state         <= S_FAIL;
              bus.align_err <= 1'b1;
            end else begin
              state       <= S_SLIP;
              bus.bitslip <= 1'b1;
            end
          end

          S_SLIP: begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            if (bus.slip_count != SLIP_MAX) begin
              bus.slip_count <= bus.slip_count + 4'd1;
            end
          end

          S_LOCKED: begin
            if (frm_match) begin
              miss_cnt    <= '0;
              bus.aligned <= 1'b1;
            end else if (miss_cnt == LOSS_LAST) begin
              // Lock lost: start over from a clean slip count.
              state          <= S_SETTLE;
              settle_cnt     <= '0;
              miss_cnt       <= '0;
              bus.slip_count <= '0;
              if (bus.relock_cnt != 8'hFF) begin
                bus.relock_cnt <= bus.relock_cnt + 8'd1;
              end
            end else begin
              miss_cnt    <= miss_cnt + 8'd1;
              bus.aligned <= 1'b1;
            end
          end

          S_FAIL: begin
            // Parked until adc_en drops or restart pulses.
            bus.align_err <= 1'b1;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_align.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_align
// Bench for adc_frame_align. A deserializer model rotates its word left by one
// bit on every bitslip pulse; an override lets a test inject mismatching
// words. Expected bitslip cycles are queued when stimulus is driven and a
// monitor pops and compares them as pulses appear.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_frame_align;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adc_frame_align_if bus_if ();

  adc_frame_align dut (
    .adc_clk (clk),
    .adc_rst (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;
  int slip_q[$];

  logic [7:0] base_word = 8'hF0;
  logic       force_en  = 1'b0;
  logic [7:0] force_val = 8'h00;

  assign bus_if.frm_data = force_en ? force_val : base_word;

  always @(posedge clk) cyc <= cyc + 1;

  // Deserializer model: one left rotation per bitslip pulse.
  always @(posedge clk) begin
    if (bus_if.bitslip === 1'b1) base_word <= {base_word[6:0], base_word[7]};
  end

  // Bitslip scoreboard: sampled 1 ns after the edge.
  always @(posedge clk) begin
    int exp_cyc;
    #1;
    if (bus_if.bitslip === 1'b1) begin
      assert_cnt++;
      if (slip_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL unexpected_bitslip: pulse at cycle %0d, none expected", cyc);
      end else begin
        exp_cyc = slip_q.pop_front();
        if (exp_cyc != cyc) begin
          fail_cnt++;
          $display("FAIL bitslip_time: pulse at cycle %0d, expected cycle %0d", cyc, exp_cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges; inputs are driven and outputs read 2 ns after.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    bus_if.adc_en  = 1'b0;
    bus_if.restart = 1'b0;
    base_word      = 8'hF0;
    rst            = 1'b1;
    step(3);
    assert_cnt++;
    if ({bus_if.bitslip, bus_if.aligned, bus_if.align_err, bus_if.slip_count,
         bus_if.relock_cnt} !== 15'h0) begin
      fail_cnt++;
      $display("FAIL reset_state: outputs=%h expected 0",
               {bus_if.bitslip, bus_if.aligned, bus_if.align_err,
                bus_if.slip_count, bus_if.relock_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_aligned_start();
    bus_if.adc_en = 1'b1;
    step(80);
    assert_cnt++;
    if (bus_if.aligned !== 1'b0) begin
      fail_cnt++;
      $display("FAIL t1_early_lock: aligned=%b expected 0 at 80 cycles", bus_if.aligned);
    end
    step(1);
    assert_cnt++;
    if (bus_if.aligned !== 1'b1) begin
      fail_cnt++;
      $display("FAIL t1_lock: aligned=%b expected 1 at 81 cycles", bus_if.aligned);
    end
    assert_cnt++;
    if (bus_if.slip_count !== 4'd0) begin
      fail_cnt++;
      $display("FAIL t1_slip_count: got %0d expected 0", bus_if.slip_count);
    end
  endtask

  task automatic test_rotated_word();
    int c0;
    bus_if.adc_en = 1'b0;
    step(1);
    base_word     = 8'h87;
    bus_if.adc_en = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 5; k++) slip_q.push_back(c0 + 18 * k);
    step(170);
    assert_cnt++;
    if (bus_if.aligned !== 1'b0) begin
      fail_cnt++;
      $display("FAIL t2_early_lock: aligned=%b expected 0", bus_if.aligned);
    end
    step(1);
    assert_cnt++;
    if (bus_if.aligned !== 1'b1) begin
      fail_cnt++;
      $display("FAIL t2_lock: aligned=%b expected 1", bus_if.aligned);
    end
    assert_cnt++;
    if (bus_if.slip_count !== 4'd5) begin
      fail_cnt++;
      $display("FAIL t2_slip_count: got %0d expected 5", bus_if.slip_count);
    end
    assert_cnt++;
    if (slip_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL t2_missing_bitslip: %0d pulses still expected", slip_q.size());
    end
  endtask

  task automatic test_never_match();
    int c0;
    bus_if.adc_en = 1'b0;
    step(1);
    base_word     = 8'h00;
    bus_if.adc_en = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 8; k++) slip_q.push_back(c0 + 18 * k);
    step(161);
    assert_cnt++;
    if (bus_if.align_err !== 1'b0) begin
      fail_cnt++;
      $display("FAIL t3_early_err: align_err=%b expected 0", bus_if.align_err);
    end
    step(1);
    assert_cnt++;
    if (bus_if.align_err !== 1'b1 || bus_if.slip_count !== 4'd8) begin
      fail_cnt++;
      $display("FAIL t3_fail_state: align_err=%b slip_count=%0d expected 1 and 8",
               bus_if.align_err, bus_if.slip_count);
    end
    assert_cnt++;
    if (slip_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL t3_missing_bitslip: %0d pulses still expected", slip_q.size());
    end
    step(40);
    assert_cnt++;
    if (bus_if.align_err !== 1'b1) begin
      fail_cnt++;
      $display("FAIL t3_err_hold: align_err=%b expected 1", bus_if.align_err);
    end
    bus_if.restart = 1'b1;
    c0 = cyc;
    slip_q.push_back(c0 + 18);
    step(1);
    bus_if.restart = 1'b0;
    assert_cnt++;
    if (bus_if.slip_count !== 4'd0 || bus_if.align_err !== 1'b0) begin
      fail_cnt++;
      $display("FAIL t3_restart: slip_count=%0d align_err=%b expected 0 and 0",
               bus_if.slip_count, bus_if.align_err);
    end
    step(17);
    assert_cnt++;
    if (slip_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL t3_restart_attempt: %0d pulses still expected", slip_q.size());
    end
    bus_if.adc_en = 1'b0;
    step(1);
  endtask

  task automatic test_lock_loss();
    base_word     = 8'hF0;
    bus_if.adc_en = 1'b1;
    step(81);
    assert_cnt++;
    if (bus_if.aligned !== 1'b1) begin
      fail_cnt++;
      $display("FAIL t4_lock: aligned=%b expected 1", bus_if.aligned);
    end
    force_val = 8'h0F;
    force_en  = 1'b1;
    step(3);
    force_en  = 1'b0;
    step(1);
    assert_cnt++;
    if (bus_if.aligned !== 1'b1 || bus_if.relock_cnt !== 8'd0) begin
      fail_cnt++;
      $display("FAIL t4_glitch: aligned=%b relock_cnt=%0d expected 1 and 0",
               bus_if.aligned, bus_if.relock_cnt);
    end
    force_en = 1'b1;
    step(3);
    assert_cnt++;
    if (bus_if.aligned !== 1'b1) begin
      fail_cnt++;
      $display("FAIL t4_three_miss: aligned=%b expected 1", bus_if.aligned);
    end
    step(1);
    force_en = 1'b0;
    assert_cnt++;
    if (bus_if.aligned !== 1'b0 || bus_if.relock_cnt !== 8'd1) begin
      fail_cnt++;
      $display("FAIL t4_loss: aligned=%b relock_cnt=%0d expected 0 and 1",
               bus_if.aligned, bus_if.relock_cnt);
    end
    step(79);
    assert_cnt++;
    if (bus_if.aligned !== 1'b0) begin
      fail_cnt++;
      $display("FAIL t4_early_relock: aligned=%b expected 0", bus_if.aligned);
    end
    step(1);
    assert_cnt++;
    if (bus_if.aligned !== 1'b1) begin
      fail_cnt++;
      $display("FAIL t4_relock: aligned=%b expected 1", bus_if.aligned);
    end
  endtask

  task automatic test_disable_mid();
    int c0;
    bus_if.adc_en = 1'b0;
    step(1);
    base_word     = 8'h87;
    bus_if.adc_en = 1'b1;
    c0 = cyc;
    slip_q.push_back(c0 + 18);
    slip_q.push_back(c0 + 36);
    step(40);
    assert_cnt++;
    if (bus_if.slip_count !== 4'd2) begin
      fail_cnt++;
      $display("FAIL t5_two_slips: slip_count=%0d expected 2", bus_if.slip_count);
    end
    bus_if.adc_en = 1'b0;
    step(1);
    assert_cnt++;
    if (bus_if.slip_count !== 4'd0 || bus_if.aligned !== 1'b0 ||
        bus_if.bitslip !== 1'b0) begin
      fail_cnt++;
      $display("FAIL t5_idle: slip_count=%0d aligned=%b bitslip=%b expected 0 0 0",
               bus_if.slip_count, bus_if.aligned, bus_if.bitslip);
    end
    // The model has rotated twice (87 -> 0F -> 1E): three more slips remain.
    bus_if.adc_en = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 3; k++) slip_q.push_back(c0 + 18 * k);
    step(134);
    assert_cnt++;
    if (bus_if.aligned !== 1'b0) begin
      fail_cnt++;
      $display("FAIL t5_early_lock: aligned=%b expected 0", bus_if.aligned);
    end
    step(1);
    assert_cnt++;
    if (bus_if.aligned !== 1'b1 || bus_if.slip_count !== 4'd3) begin
      fail_cnt++;
      $display("FAIL t5_lock: aligned=%b slip_count=%0d expected 1 and 3",
               bus_if.aligned, bus_if.slip_count);
    end
    assert_cnt++;
    if (slip_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL t5_missing_bitslip: %0d pulses still expected", slip_q.size());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      force_val = 8'h0F;
      force_en  = 1'b1;
      step(4);
      force_en  = 1'b0;
      step(80);
    end
    assert_cnt++;
    if (bus_if.aligned !== 1'b1 || bus_if.relock_cnt !== 8'd3) begin
      fail_cnt++;
      $display("FAIL t6_pre_reset: aligned=%b relock_cnt=%0d expected 1 and 3",
               bus_if.aligned, bus_if.relock_cnt);
    end
    rst = 1'b1;
    #2;
    assert_cnt++;
    if ({bus_if.bitslip, bus_if.aligned, bus_if.align_err, bus_if.slip_count,
         bus_if.relock_cnt} !== 15'h0) begin
      fail_cnt++;
      $display("FAIL t6_async_reset: outputs=%h expected 0 before any edge",
               {bus_if.bitslip, bus_if.aligned, bus_if.align_err,
                bus_if.slip_count, bus_if.relock_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    step(80);
    assert_cnt++;
    if (bus_if.aligned !== 1'b0) begin
      fail_cnt++;
      $display("FAIL t6_early_lock: aligned=%b expected 0", bus_if.aligned);
    end
    step(1);
    assert_cnt++;
    if (bus_if.aligned !== 1'b1 || bus_if.relock_cnt !== 8'd0) begin
      fail_cnt++;
      $display("FAIL t6_resume: aligned=%b relock_cnt=%0d expected 1 and 0",
               bus_if.aligned, bus_if.relock_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_start();
    test_rotated_word();
    test_never_match();
    test_lock_loss();
    test_disable_mid();
    test_async_reset();
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
